// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared widths, memory depth, halt encoding and FSM states
package fetch_sequencer_pkg;
   localparam int WORD = 32;
   localparam int INS_SIZE = 512;
   localparam logic [WORD-1:0] HALT_INSTR = 32'hFFFF_FFFF;
   typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_HALT} state_e;
endpackage

// File: rtl/fetch_sequencer_load_writer.sv
// fetch_sequencer_load_writer: write pointer and loader handshake into instruction memory
module fetch_sequencer_load_writer
   import fetch_sequencer_pkg::*;
#(
   parameter int DEPTH = INS_SIZE
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en_i,
   input  logic            load_valid_i,
   input  logic [WORD-1:0] load_data_i,
   input  logic            load_last_i,
   output logic            load_ready_o,
   output logic            mem_we_o,
   output logic [WORD-1:0] mem_waddr_o,
   output logic [WORD-1:0] mem_wdata_o,
   output logic            done_o
);
   logic [WORD-1:0] wptr_q, wptr_d;
   logic accept;
   assign accept = en_i && load_valid_i;
   assign load_ready_o = en_i;
   assign mem_we_o = accept;
   assign mem_waddr_o = wptr_q;
   assign mem_wdata_o = load_data_i;
   // The word landing in the last slot ends the load even without load_last.
   assign done_o = accept && (load_last_i || wptr_q == WORD'(DEPTH - 1));
   assign wptr_d = accept ? wptr_q + 1 : wptr_q;
   always_ff @(posedge clk) begin
      if (rst) wptr_q <= '0;
      else wptr_q <= wptr_d;
   end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: loads the program, then sequences the PC into registered IF/ID outputs
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int DEPTH = INS_SIZE
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_valid,
   input  logic [WORD-1:0] load_data,
   input  logic            load_last,
   output logic            load_ready,
   output logic            mem_we,
   output logic [WORD-1:0] mem_waddr,
   output logic [WORD-1:0] mem_wdata,
   output logic [WORD-1:0] pc_out,
   input  logic [WORD-1:0] mem_in,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [WORD-1:0] redirect_pc,
   output logic [WORD-1:0] if_instr,
   output logic [WORD-1:0] if_pc,
   output logic            if_valid,
   output logic            halted
);
   localparam logic [WORD-1:0] LAST_PC = WORD'((DEPTH - 1) * 4);
   localparam logic [WORD-1:0] MEM_BYTES = WORD'(DEPTH * 4);
   state_e state_q, state_d;
   logic [WORD-1:0] pc_q, pc_d, instr_q, instr_d, ipc_q, ipc_d;
   logic valid_q, valid_d, load_done;
   fetch_sequencer_load_writer #(.DEPTH(DEPTH)) u_load_writer (
      .clk          (clk),
      .rst          (rst),
      .en_i         (state_q == ST_LOAD),
      .load_valid_i (load_valid),
      .load_data_i  (load_data),
      .load_last_i  (load_last),
      .load_ready_o (load_ready),
      .mem_we_o     (mem_we),
      .mem_waddr_o  (mem_waddr),
      .mem_wdata_o  (mem_wdata),
      .done_o       (load_done)
   );
   always_comb begin
      state_d = state_q;
      pc_d = pc_q;
      instr_d = instr_q;
      ipc_d = ipc_q;
      valid_d = valid_q;
      case (state_q)
         ST_LOAD: begin
            valid_d = 1'b0;
            state_d = load_done ? ST_RUN : ST_LOAD;
            pc_d = '0;
         end
         ST_RUN: begin
            if (redirect_valid) begin
               pc_d = {redirect_pc[WORD-1:2], 2'b00};
               instr_d = '0;
               valid_d = 1'b0;
               state_d = redirect_pc >= MEM_BYTES ? ST_HALT : ST_RUN;
            end else if (!stall) begin
               instr_d = mem_in;
               ipc_d = pc_q;
               valid_d = 1'b1;
               // Halt word and the final slot both stop with the PC parked, never wrapping.
               if (mem_in == HALT_INSTR || pc_q == LAST_PC) state_d = ST_HALT;
               else pc_d = pc_q + 4;
            end
         end
         default: valid_d = stall & valid_q;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_LOAD;
         pc_q <= '0;
         instr_q <= '0;
         ipc_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q <= pc_d;
         instr_q <= instr_d;
         ipc_q <= ipc_d;
         valid_q <= valid_d;
      end
   end
   assign pc_out = pc_q;
   assign if_instr = instr_q;
   assign if_pc = ipc_q;
   assign if_valid = valid_q;
   assign halted = state_q == ST_HALT;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed program loads and fetch sequences against an 8-word memory,
// with write and fetch scoreboards checked by a negedge monitor.
module tb_fetch_sequencer;
   logic clk = 1'b0, rst = 1'b1, load_valid = 1'b0, load_last = 1'b0;
   logic stall = 1'b0, redirect_valid = 1'b0, stall_seen = 1'b0;
   logic [31:0] load_data = '0, redirect_pc = '0;
   logic [31:0] mem_in, pc_out, mem_waddr, mem_wdata, if_instr, if_pc;
   logic load_ready, mem_we, if_valid, halted;
   logic [31:0] imem [8] = '{32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003,
                             32'hC0DE_0004, 32'hC0DE_0005, 32'hC0DE_0006, 32'hC0DE_0007};
   logic [31:0] prog [10];
   logic [63:0] fetch_q[$], write_q[$];
   int vectors = 0, miscompares = 0;
   always #5 clk = ~clk;
   fetch_sequencer #(.DEPTH(8)) dut (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
      .load_ready(load_ready), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .pc_out(pc_out), .mem_in(mem_in), .stall(stall), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
      .halted(halted)
   );
   assign mem_in = imem[pc_out[4:2]];
   always @(posedge clk) begin
      if (mem_we === 1'b1) imem[mem_waddr[2:0]] <= mem_wdata;
      stall_seen <= stall;
   end
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask
   // A fresh IF/ID delivery is any valid cycle whose preceding edge was not stalled.
   always @(negedge clk) begin
      logic [63:0] e;
      if (mem_we === 1'b1) begin
         if (write_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL spurious_write: addr %h data %h, expected no write", mem_waddr, mem_wdata);
         end else begin
            e = write_q.pop_front();
            check("write_addr", mem_waddr, e[63:32]);
            check("write_data", mem_wdata, e[31:0]);
         end
      end
      if (if_valid === 1'b1 && !stall_seen) begin
         if (fetch_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL spurious_fetch: if_pc %h if_instr %h, expected none", if_pc, if_instr);
         end else begin
            e = fetch_q.pop_front();
            check("if_pc", if_pc, e[63:32]);
            check("if_instr", if_instr, e[31:0]);
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
      fetch_q.push_back({pc, instr});
      tick();
   endtask
   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask
   task automatic load(input int n, input bit last);
      for (int i = 0; i < n; i++) begin
         load_valid = 1'b1;
         load_data = prog[i];
         load_last = last && i == n - 1;
         check("load_ready", load_ready, i < 8);
         if (i < 8) write_q.push_back({32'(i), prog[i]});
         else fetch_q.push_back({32'((i - 8) * 4), prog[i - 8]});
         tick();
      end
      load_valid = 1'b0;
      load_last = 1'b0;
   endtask
   initial begin
      do_reset();
      check("rst_if_valid", if_valid, 0);
      check("rst_if_instr", if_instr, 0);
      check("rst_if_pc", if_pc, 0);
      check("rst_pc_out", pc_out, 0);
      check("rst_halted", halted, 0);
      check("rst_load_ready", load_ready, 1);
      check("rst_mem_we", mem_we, 0);
      // Four-word program, stall, stall+redirect, then run off the end of memory.
      prog[0] = 32'hA000_000A; prog[1] = 32'hB000_000B;
      prog[2] = 32'hC000_000C; prog[3] = 32'hD000_000D;
      load(4, 1'b1);
      check("run_load_ready", load_ready, 0);
      check("run_pc0", pc_out, 0);
      fetch(0, 32'hA000_000A);
      fetch(4, 32'hB000_000B);
      check("pre_stall_pc", pc_out, 8);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_pc_out", pc_out, 8);
         check("stall_if_pc", if_pc, 4);
         check("stall_if_instr", if_instr, 32'hB000_000B);
         check("stall_if_valid", if_valid, 1);
      end
      stall = 1'b0;
      fetch(8, 32'hC000_000C);
      stall = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0011;
      tick();
      stall = 1'b0;
      redirect_valid = 1'b0;
      check("redir_if_valid", if_valid, 0);
      check("redir_if_instr", if_instr, 0);
      check("redir_pc_out", pc_out, 32'h10);
      fetch(16, 32'hC0DE_0004);
      fetch(20, 32'hC0DE_0005);
      fetch(24, 32'hC0DE_0006);
      fetch(28, 32'hC0DE_0007);
      check("eom_halted", halted, 1);
      check("eom_if_valid", if_valid, 1);
      check("eom_pc_hold", pc_out, 28);
      tick();
      check("eom_if_valid_drop", if_valid, 0);
      // Halt word at index 2; a later redirect must be ignored.
      do_reset();
      prog[0] = 32'h1111_0001; prog[1] = 32'h2222_0002; prog[2] = 32'hFFFF_FFFF;
      load(3, 1'b1);
      fetch(0, 32'h1111_0001);
      fetch(4, 32'h2222_0002);
      fetch(8, 32'hFFFF_FFFF);
      check("halt_halted", halted, 1);
      check("halt_if_valid", if_valid, 1);
      check("halt_pc_hold", pc_out, 8);
      tick();
      check("halt_if_valid_drop", if_valid, 0);
      redirect_valid = 1'b1;
      redirect_pc = 32'h0;
      tick();
      redirect_valid = 1'b0;
      check("halt_redir_pc", pc_out, 8);
      check("halt_redir_halted", halted, 1);
      check("halt_redir_valid", if_valid, 0);
      // Ten words streamed with no load_last: only eight land, then RUN.
      do_reset();
      for (int i = 0; i < 10; i++) prog[i] = 32'hF000_0000 + 32'(i);
      load(10, 1'b0);
      for (int i = 2; i < 8; i++) fetch(32'(i * 4), 32'hF000_0000 + 32'(i));
      check("full_halted", halted, 1);
      check("full_if_pc", if_pc, 28);
      tick();
      check("full_if_valid_drop", if_valid, 0);
      // Reset in the middle of RUN, then an out-of-range redirect.
      do_reset();
      prog[0] = 32'h1234_5678;
      load(1, 1'b1);
      fetch(0, 32'h1234_5678);
      fetch(4, 32'hF000_0001);
      check("mid_pc", pc_out, 8);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_if_valid", if_valid, 0);
      check("midrst_pc", pc_out, 0);
      check("midrst_load_ready", load_ready, 1);
      check("midrst_halted", halted, 0);
      check("midrst_if_instr", if_instr, 0);
      prog[0] = 32'hABCD_0001;
      load(1, 1'b1);
      fetch(0, 32'hABCD_0001);
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0040;
      tick();
      redirect_valid = 1'b0;
      check("oor_halted", halted, 1);
      check("oor_if_valid", if_valid, 0);
      tick();
      tick();
      check("fetch_queue_left", fetch_q.size(), 0);
      check("write_queue_left", write_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
